pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 40, meaning the maximum number of MD_BUSY cycles before a forced release.
REQ-002 SHALL have ports `clk  input  1`: the single clock, rising-edge.
REQ-003 SHALL have ports `reset  input  1`: asynchronous reset, active-low.
REQ-004 SHALL have ports `fd_ir  input  32`: instruction word held in the F/D latch.
REQ-005 SHALL have ports `dx_ir  input  32`: instruction word held in the D/X latch.
REQ-006 SHALL have ports `branch_taken  input  1`: the X stage resolved a taken branch or jump this cycle.
REQ-007 SHALL have ports `md_ready  input  1`: the multiply/divide unit result is valid.
REQ-008 SHALL have ports `pc_we, fd_we, dx_we  output  1 each`: write enables for the PC, F/D and D/X latches.
REQ-009 SHALL have ports `fd_flush  output  1`: the F/D latch loads a NOP instead of IR_in.
REQ-010 SHALL have ports `dx_bubble  output  1`: the D/X latch loads a NOP.
REQ-011 SHALL have ports `xm_bubble  output  1`: the X/M latch loads a NOP.
REQ-012 SHALL have ports `md_mult, md_div  output  1`: one-cycle start pulses to the multiply/divide unit.
REQ-013 SHALL have ports `md_timeout  output  1`: one-cycle pulse on forced release.
REQ-014 SHALL have ports `stall_count  output  16`: count of stall cycles.

Function
REQ-015 SHALL decode instruction fields as follows: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
- lw = opcode 01000.
- sw = opcode 00111.
- mul = opcode 00000 with ALU op 00110.
- div = opcode 00000 with ALU op 00111.
REQ-016 SHALL implement a two-state FSM: RUN and MD_BUSY.
REQ-017 In RUN with dx_ir = mul or div, SHALL:
- assert md_mult or md_div for that one cycle;
- drive pc_we = fd_we = dx_we = 0 and xm_bubble = 1;
- enter MD_BUSY at the next edge.
REQ-018 SHALL ignore md_ready during the issue cycle of REQ-017.
REQ-019 In MD_BUSY with md_ready = 0, SHALL drive pc_we = fd_we = dx_we = 0 and xm_bubble = 1, and increment an internal 6-bit md_cnt.
REQ-020 In MD_BUSY with md_ready = 1, SHALL drive pc_we = fd_we = dx_we = 1 and xm_bubble = 0, and return to RUN at the next edge with md_cnt cleared.
REQ-021 In MD_BUSY when md_cnt = MD_TIMEOUT-1 and md_ready = 0, SHALL pulse md_timeout and behave as in REQ-020.
REQ-022 In RUN with branch_taken = 1 (and no mul/div in D/X), SHALL assert fd_flush = 1 and dx_bubble = 1 with pc_we = fd_we = dx_we = 1.
REQ-023 In RUN, SHALL detect load-use when dx_ir is lw, dx rd != 0, and at least one of the following holds:
- fd rs = dx rd;
- fd opcode = 00000 and fd rt = dx rd;
- fd opcode = sw and fd rd = dx rd.
REQ-024 On load-use (REQ-023), SHALL drive pc_we = fd_we = 0, dx_we = 1 and dx_bubble = 1 for exactly one cycle.
REQ-025 SHALL apply priority mul/div stall > branch flush > load-use; lower-priority actions are suppressed that cycle.
REQ-026 With no hazard, SHALL drive pc_we = fd_we = dx_we = 1 and all bubble, flush and pulse outputs 0.
REQ-027 SHALL increment stall_count in every cycle where pc_we = 0 (while reset is high), saturating at 16'hFFFF.
REQ-028 SHALL make all outputs combinational from state and current inputs; no output is registered except stall_count.

Reset
REQ-029 While reset = 0, SHALL force:
- state = RUN and md_cnt = 0;
- stall_count = 0;
- pc_we = fd_we = dx_we = 0;
- all flush, bubble, pulse and timeout outputs 0.
REQ-030 SHALL abandon any pending multiply/divide on reset mid-MD_BUSY, with no md_timeout and no further pulses after release.
REQ-031 SHALL resume normal RUN decoding in the first cycle after reset deasserts.

Verification
REQ-032 Reset release with NOP in both latches -> pc_we = fd_we = dx_we = 1, stall_count = 0.
REQ-033 dx_ir = lw r5, fd_ir = add r1,r5,r2 -> one cycle pc_we = 0, dx_bubble = 1, then resume; stall_count = 1.
REQ-034 dx_ir = mul, md_ready high 3 cycles after issue -> md_mult for 1 cycle, 4 frozen cycles, xm_bubble = 1 throughout, released in the md_ready cycle; stall_count = 4.
REQ-035 dx_ir = div, md_ready never asserts -> md_timeout pulse in cycle MD_TIMEOUT (40) of MD_BUSY, then RUN.
REQ-036 branch_taken = 1 coincident with load-use -> fd_flush = 1, dx_bubble = 1, pc_we = 1; no stall counted.
REQ-037 reset low mid-MD_BUSY, then md_ready = 1 -> after release state RUN, stall_count = 0, no md_timeout.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Hazard controller for a five-stage in-order pipeline. It watches the
// instructions in the F/D and D/X latches and produces latch write enables,
// flush/bubble controls and multiply/divide start pulses.
//
// Three hazards are handled. Their priority is mul/div stall, then branch
// flush, then load-use:
//   - mul/div in D/X: the unit is started and the front end freezes until
//     md_ready or a timeout forces release.
//   - taken branch in X: the wrong-path F/D and D/X contents are squashed.
//   - load-use: the pipeline stalls for one cycle with a bubble in D/X.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active low
//   fd_ir        in   [31:0] instruction in the F/D latch
//   dx_ir        in   [31:0] instruction in the D/X latch
//   branch_taken in   X stage resolved a taken branch/jump this cycle
//   md_ready     in   multiply/divide result valid
//   pc_we        out  PC write enable
//   fd_we        out  F/D latch write enable
//   dx_we        out  D/X latch write enable
//   fd_flush     out  F/D latch loads a NOP
//   dx_bubble    out  D/X latch loads a NOP
//   xm_bubble    out  X/M latch loads a NOP
//   md_mult      out  one-cycle multiply start pulse
//   md_div       out  one-cycle divide start pulse
//   md_timeout   out  one-cycle pulse when a mul/div wait is forcibly released
//   stall_count  out  [15:0] saturating count of cycles with pc_we low

module pipeline_hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        fd_flush,
    output logic        dx_bubble,
    output logic        xm_bubble,
    output logic        md_mult,
    output logic        md_div,
    output logic        md_timeout,
    output logic [15:0] stall_count
);

    localparam logic [4:0] OpRtype = 5'b00000;
    localparam logic [4:0] OpLw    = 5'b01000;
    localparam logic [4:0] OpSw    = 5'b00111;
    localparam logic [4:0] AluMul  = 5'b00110;
    localparam logic [4:0] AluDiv  = 5'b00111;

    // md_cnt value of the last MD_BUSY cycle allowed to wait on md_ready
    localparam logic [5:0] MdLast = 6'(MD_TIMEOUT - 1);

    typedef enum logic [0:0] {StRun, StMdBusy} state_e;

    state_e      state_q, state_d;
    logic [5:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;

    // Instruction field decode
    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_alu;

    assign fd_op  = fd_ir[31:27];
    assign fd_rd  = fd_ir[26:22];
    assign fd_rs  = fd_ir[21:17];
    assign fd_rt  = fd_ir[16:12];
    assign dx_op  = dx_ir[31:27];
    assign dx_rd  = dx_ir[26:22];
    assign dx_alu = dx_ir[6:2];

    // Fields of the instruction words this block has no use for
    logic unused_ir;
    assign unused_ir = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

    logic dx_is_mul, dx_is_div, dx_is_md, load_use;

    assign dx_is_mul = (dx_op == OpRtype) && (dx_alu == AluMul);
    assign dx_is_div = (dx_op == OpRtype) && (dx_alu == AluDiv);
    assign dx_is_md  = dx_is_mul || dx_is_div;

    // A load result is not available for forwarding to the very next
    // instruction; rd of a store is a source register, hence the sw term.
    assign load_use = (dx_op == OpLw) && (dx_rd != 5'd0) &&
                      ((fd_rs == dx_rd) ||
                       ((fd_op == OpRtype) && (fd_rt == dx_rd)) ||
                       ((fd_op == OpSw) && (fd_rd == dx_rd)));

    always_comb begin
        state_d    = state_q;
        md_cnt_d   = md_cnt_q;
        pc_we      = 1'b1;
        fd_we      = 1'b1;
        dx_we      = 1'b1;
        fd_flush   = 1'b0;
        dx_bubble  = 1'b0;
        xm_bubble  = 1'b0;
        md_mult    = 1'b0;
        md_div     = 1'b0;
        md_timeout = 1'b0;

        unique case (state_q)
            StRun: begin
                if (dx_is_md) begin
                    // Issue cycle: md_ready is deliberately not looked at
                    md_mult   = dx_is_mul;
                    md_div    = dx_is_div;
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    dx_we     = 1'b0;
                    xm_bubble = 1'b1;
                    state_d   = StMdBusy;
                    md_cnt_d  = 6'd0;
                end else if (branch_taken) begin
                    fd_flush  = 1'b1;
                    dx_bubble = 1'b1;
                end else if (load_use) begin
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    dx_bubble = 1'b1;
                end
            end
            StMdBusy: begin
                if (md_ready || (md_cnt_q == MdLast)) begin
                    md_timeout = !md_ready;
                    state_d    = StRun;
                    md_cnt_d   = 6'd0;
                end else begin
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    dx_we     = 1'b0;
                    xm_bubble = 1'b1;
                    md_cnt_d  = md_cnt_q + 6'd1;
                end
            end
            default: begin
                state_d  = StRun;
                md_cnt_d = 6'd0;
            end
        endcase

        // Everything is held quiet while reset is asserted
        if (!reset) begin
            pc_we      = 1'b0;
            fd_we      = 1'b0;
            dx_we      = 1'b0;
            fd_flush   = 1'b0;
            dx_bubble  = 1'b0;
            xm_bubble  = 1'b0;
            md_mult    = 1'b0;
            md_div     = 1'b0;
            md_timeout = 1'b0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_we && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StRun;
            md_cnt_q      <= 6'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a table of single-cycle
// decode vectors, hand-written multi-cycle sequences, and a randomized run
// compared against a cycle-level reference model.

module tb_pipeline_hazard_ctrl;

    localparam int unsigned MdTimeout = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fd_ir, dx_ir;
    logic        branch_taken, md_ready;
    logic        pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble;
    logic        md_mult, md_div, md_timeout;
    logic [15:0] stall_count;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(MdTimeout)) dut (
        .clk          (clk),
        .reset        (reset),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .pc_we        (pc_we),
        .fd_we        (fd_we),
        .dx_we        (dx_we),
        .fd_flush     (fd_flush),
        .dx_bubble    (dx_bubble),
        .xm_bubble    (xm_bubble),
        .md_mult      (md_mult),
        .md_div       (md_div),
        .md_timeout   (md_timeout),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    // Output vector order: pc fd dx flush dxb xmb mult div timeout
    localparam logic [8:0] ORun    = 9'b111000000;
    localparam logic [8:0] OLoad   = 9'b001010000;
    localparam logic [8:0] OBranch = 9'b111110000;
    localparam logic [8:0] OMul    = 9'b000001100;
    localparam logic [8:0] ODiv    = 9'b000001010;
    localparam logic [8:0] OFrozen = 9'b000001000;
    localparam logic [8:0] OTmo    = 9'b111000001;
    localparam logic [8:0] OQuiet  = 9'b000000000;

    function automatic logic [31:0] enc(input logic [4:0] op, rd, rs, rt, alu);
        enc = {op, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    localparam logic [31:0] Nop = 32'h0000_0000;

    // ---------------- reference model ----------------
    bit m_busy;      // waiting on the multiply/divide unit
    int m_waited;    // busy cycles already spent waiting
    int m_stalls;

    function automatic bit is_md(input logic [31:0] ir);
        logic [4:0] op, alu;
        op  = ir[31:27];
        alu = ir[6:2];
        return op == 5'd0 && (alu == 5'd6 || alu == 5'd7);
    endfunction

    function automatic bit needs_load(input logic [31:0] fd, dx);
        logic [4:0] lrd;
        lrd = dx[26:22];
        if (dx[31:27] != 5'b01000 || lrd == 0) return 0;
        if (fd[21:17] == lrd) return 1;
        if (fd[31:27] == 5'd0 && fd[16:12] == lrd) return 1;
        if (fd[31:27] == 5'b00111 && fd[26:22] == lrd) return 1;
        return 0;
    endfunction

    function automatic logic [8:0] model_out(input logic [31:0] fd, dx,
                                             input logic br, rdy, rst);
        if (!rst) return OQuiet;
        if (m_busy) begin
            if (rdy) return ORun;
            if (m_waited + 1 == int'(MdTimeout)) return OTmo;
            return OFrozen;
        end
        if (is_md(dx)) return (dx[6:2] == 5'd6) ? OMul : ODiv;
        if (br) return OBranch;
        if (needs_load(fd, dx)) return OLoad;
        return ORun;
    endfunction

    task automatic check(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, sample at the falling edge, compare with the
    // model, advance the model, then move to just after the next rising edge.
    task automatic step(input logic [31:0] fd, dx, input logic br, rdy, rst,
                        output logic [8:0] act, output logic [15:0] act_sc);
        logic [8:0] exp;
        int exp_sc;
        fd_ir = fd; dx_ir = dx; branch_taken = br; md_ready = rdy; reset = rst;
        #4;
        exp    = model_out(fd, dx, br, rdy, rst);
        exp_sc = rst ? m_stalls : 0;
        act    = {pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble,
                  md_mult, md_div, md_timeout};
        act_sc = stall_count;
        check("model_outputs", 32'(act), 32'(exp));
        check("model_stall_count", 32'(act_sc), 32'(exp_sc));
        if (!rst) begin
            m_busy = 0; m_waited = 0; m_stalls = 0;
        end else begin
            if (!exp[8] && m_stalls < 65535) m_stalls++;
            if (m_busy) begin
                if (exp[8]) begin m_busy = 0; m_waited = 0; end
                else m_waited++;
            end else if (is_md(dx)) begin
                m_busy = 1; m_waited = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        string       name;
        logic [31:0] fd;
        logic [31:0] dx;
        logic        br;
        logic [8:0]  exp;
    } vec_t;

    function automatic logic [31:0] rand_ir();
        logic [4:0] op, alu;
        case ($urandom_range(3))
            0: op = 5'b01000;
            1: op = 5'b00111;
            2: op = 5'b00000;
            default: op = 5'($urandom);
        endcase
        case ($urandom_range(3))
            0: alu = 5'd6;
            1: alu = 5'd7;
            default: alu = 5'($urandom);
        endcase
        return enc(op, 5'($urandom_range(7)), 5'($urandom_range(7)),
                   5'($urandom_range(7)), alu);
    endfunction

    initial begin
        vec_t vecs[$];
        logic [8:0]  o;
        logic [15:0] sc;
        logic [31:0] lw5, addr5, mul, div;

        lw5   = enc(5'b01000, 5'd5, 5'd0, 5'd0, 5'd0);
        addr5 = enc(5'b00000, 5'd1, 5'd5, 5'd2, 5'd0);
        mul   = enc(5'b00000, 5'd3, 5'd1, 5'd2, 5'd6);
        div   = enc(5'b00000, 5'd3, 5'd1, 5'd2, 5'd7);

        vecs.push_back('{"nop_nop",      Nop, Nop, 1'b0, ORun});
        vecs.push_back('{"lu_rs",        addr5, lw5, 1'b0, OLoad});
        vecs.push_back('{"lu_rt_rtype",  enc(5'd0, 5'd1, 5'd2, 5'd5, 5'd0), lw5, 1'b0, OLoad});
        vecs.push_back('{"lu_sw_rd",     enc(5'b00111, 5'd5, 5'd3, 5'd4, 5'd0), lw5, 1'b0, OLoad});
        vecs.push_back('{"lw_r0",        Nop, enc(5'b01000, 5'd0, 5'd1, 5'd0, 5'd0), 1'b0, ORun});
        vecs.push_back('{"rt_not_rtype", enc(5'b00101, 5'd1, 5'd2, 5'd5, 5'd0), lw5, 1'b0, ORun});
        vecs.push_back('{"rd_not_sw",    enc(5'b01000, 5'd5, 5'd2, 5'd3, 5'd0), lw5, 1'b0, ORun});
        vecs.push_back('{"sw_in_dx",     addr5, enc(5'b00111, 5'd5, 5'd0, 5'd0, 5'd0), 1'b0, ORun});
        vecs.push_back('{"br_over_lu",   addr5, lw5, 1'b1, OBranch});
        vecs.push_back('{"alu5_rtype",   Nop, enc(5'd0, 5'd3, 5'd1, 5'd2, 5'd5), 1'b0, ORun});
        vecs.push_back('{"alu6_not_rt",  Nop, enc(5'b00001, 5'd3, 5'd1, 5'd2, 5'd6), 1'b0, ORun});
        vecs.push_back('{"mul_over_br",  addr5, mul, 1'b1, OMul});
        vecs.push_back('{"div_issue",    Nop, div, 1'b0, ODiv});

        m_busy = 0; m_waited = 0; m_stalls = 0;
        fd_ir = Nop; dx_ir = Nop; branch_taken = 0; md_ready = 0; reset = 0;
        @(posedge clk);
        #1;

        // Reset state and first cycle after release
        step(Nop, Nop, 0, 0, 0, o, sc);
        check("reset_outputs", 32'(o), 32'(OQuiet));
        check("reset_stall_count", 32'(sc), 32'd0);
        step(Nop, Nop, 0, 0, 1, o, sc);
        check("release_outputs", 32'(o), 32'(ORun));
        check("release_stall_count", 32'(sc), 32'd0);

        foreach (vecs[i]) begin
            step(vecs[i].fd, vecs[i].dx, vecs[i].br, 1'b0, 1'b1, o, sc);
            check(vecs[i].name, 32'(o), 32'(vecs[i].exp));
            if (vecs[i].exp[2] || vecs[i].exp[1]) begin
                step(Nop, Nop, 0, 1, 1, o, sc);
                check({vecs[i].name, "_release"}, 32'(o), 32'(ORun));
            end
        end

        // Load-use: one stall cycle then resume
        step(Nop, Nop, 0, 0, 0, o, sc);
        step(addr5, lw5, 0, 0, 1, o, sc);
        check("lu_stall", 32'(o), 32'(OLoad));
        step(Nop, Nop, 0, 0, 1, o, sc);
        check("lu_resume", 32'(o), 32'(ORun));
        check("lu_stall_count", 32'(sc), 32'd1);

        // Branch coincident with load-use counts no stall
        step(addr5, lw5, 1, 0, 1, o, sc);
        step(Nop, Nop, 0, 0, 1, o, sc);
        check("br_lu_stall_count", 32'(sc), 32'd1);

        // mul: md_ready ignored at issue, three waiting cycles, then release
        step(Nop, Nop, 0, 0, 0, o, sc);
        step(Nop, mul, 0, 1, 1, o, sc);
        check("mul_issue", 32'(o), 32'(OMul));
        for (int i = 0; i < 3; i++) begin
            step(Nop, mul, 0, 0, 1, o, sc);
            check("mul_frozen", 32'(o), 32'(OFrozen));
        end
        step(Nop, mul, 0, 1, 1, o, sc);
        check("mul_release", 32'(o), 32'(ORun));
        step(Nop, Nop, 0, 0, 1, o, sc);
        check("mul_stall_count", 32'(sc), 32'd4);

        // div with md_ready never asserted: forced release in busy cycle 40
        step(Nop, Nop, 0, 0, 0, o, sc);
        step(Nop, div, 0, 0, 1, o, sc);
        check("div_issue_seq", 32'(o), 32'(ODiv));
        for (int i = 1; i < int'(MdTimeout); i++) begin
            step(Nop, div, 0, 0, 1, o, sc);
            if (o != OFrozen) check("div_waiting", 32'(o), 32'(OFrozen));
        end
        step(Nop, div, 0, 0, 1, o, sc);
        check("div_timeout", 32'(o), 32'(OTmo));
        step(Nop, Nop, 0, 0, 1, o, sc);
        check("after_timeout", 32'(o), 32'(ORun));
        check("timeout_stall_count", 32'(sc), 32'(MdTimeout));

        // Reset in the middle of a mul wait abandons it
        step(Nop, Nop, 0, 0, 0, o, sc);
        step(Nop, mul, 0, 0, 1, o, sc);
        step(Nop, mul, 0, 0, 1, o, sc);
        step(Nop, mul, 0, 0, 1, o, sc);
        step(Nop, mul, 0, 0, 0, o, sc);
        check("midbusy_reset_out", 32'(o), 32'(OQuiet));
        check("midbusy_reset_sc", 32'(sc), 32'd0);
        step(addr5, lw5, 0, 1, 1, o, sc);
        check("post_reset_decode", 32'(o), 32'(OLoad));
        step(Nop, Nop, 0, 0, 1, o, sc);
        check("post_reset_run", 32'(o), 32'(ORun));
        check("post_reset_sc", 32'(sc), 32'd1);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            step(rand_ir(), rand_ir(), 1'($urandom_range(3) == 0),
                 1'($urandom_range(3) == 0), 1'($urandom_range(63) != 0), o, sc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
